imagen_uart_tx: RTL and testbench
=================================

# imagen_uart_tx

Reads the processed image back out of image memory after the processor finishes, and transmits it pixel by pixel on a UART TX line. Its image-memory port is the read side: the processor writes `imWd`/`imWAddress`, and this block drives `imRAddress`/`imRe` and consumes `imRd`. It sits beside the processor at top level. It is the hardware path for dumping the result image to a host.

## Interface
- `ADDR_W`, 16: image-memory address width.
- `N_PIXELS`, 65536: pixels (bytes) sent per `start`, 1..2^ADDR_W.
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200), ≥2.
- `RD_LAT`, 2: image-memory read latency in cycles, 1..3.

- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: begin a dump, sampled only in IDLE.
- `base_addr`, input, ADDR_W: first pixel address, captured with `start`.
- `imRAddress`, output, ADDR_W: image-memory read address.
- `imRe`, output, 1: image-memory read enable, one-cycle pulse per pixel.
- `imRd`, input, 8: read data, valid `RD_LAT` cycles after the `imRe` cycle.
- `tx`, output, 1: UART line, idles high.
- `busy`, output, 1: high from the first cycle after an accepted `start` until `done`.
- `done`, output, 1: one-cycle pulse when the last stop bit completes.

## Operation
- Reset values: `tx`=1, `imRe`=0, `imRAddress`=0, `busy`=0, `done`=0, state IDLE, counters 0.
- Reset mid-frame: the line returns high asynchronously and the partial byte is abandoned. There is no resume.
- States: IDLE → FETCH → START → DATA → [PARITY] → STOP → (FETCH | DONE) → IDLE.
- IDLE: when `start`=1, capture `base_addr` into the address register, clear the pixel count to 0, and go to FETCH. `start` while not in IDLE is ignored.
- FETCH: `imRe`=1 on the first FETCH cycle only, with `imRAddress` = current address. Wait `RD_LAT` cycles, latch `imRd` into the shift register, then go to START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles.
- DATA: 8 bits, LSB first, each held `CLKS_PER_BIT` cycles.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles. Then increment the pixel count and the address.
  - If the count equals `N_PIXELS`, go to DONE.
  - Otherwise go to FETCH.
- Address arithmetic is modulo 2^ADDR_W, so it wraps from all-ones to 0 with no error.
- DONE: lasts one cycle with `done`=1 and `busy`=0 on that cycle, then IDLE. A `start` present in the DONE cycle is ignored. A `start` in the following IDLE cycle is accepted.
- `imRAddress` holds its last value outside FETCH. `imRe` is never high outside the first FETCH cycle.
- The block never writes image memory.

## Timing
- `start` is sampled at edge E0. From the cycle after E0: `busy`=1 and `imRe`=1 with `imRAddress`=`base_addr`.
- `imRd` is latched at edge E0+1+`RD_LAT`. `tx` falls on the cycle after that.
- Per-pixel period is exactly `RD_LAT`+1+F·`CLKS_PER_BIT` cycles, where F = 10, or 11 with parity.
- The line is high for `RD_LAT`+1 cycles between consecutive frames.
- `done` is asserted on the cycle after the last stop bit's final cycle.
- Total from E0 to the `done` cycle: N_PIXELS·(RD_LAT+1+F·CLKS_PER_BIT)+1 cycles.
- The bit counter reloads every bit. There is no fractional-baud accumulation.

## Configuration
- `IMAGEN_UART_TX_PARITY_EN` defined: an even-parity bit is inserted after bit 7 and before STOP, so F=11. The parity bit is the XOR of the 8 data bits, held for `CLKS_PER_BIT` cycles.
- Undefined: no PARITY state, F=10 (8N1).

## Test plan
Bench settings: `CLKS_PER_BIT`=4, `RD_LAT`=2, `N_PIXELS`=3, no parity, memory model with 2-cycle latency.
- Basic dump: memory at 0x0010..0x0012 = 0xA5, 0x00, 0xFF, and `start` with `base_addr`=0x0010. Expect `imRe` pulses at addresses 0x0010, 0x0011, 0x0012, 43 cycles apart. The decoded bytes are A5, 00, FF. `done` pulses exactly 130 cycles after the `start` edge.
- Bit shape: for 0xA5, `tx` reads 0, 1,0,1,0,0,1,0,1, 1, each level held exactly 4 cycles.
- Wrap-around: `base_addr`=0xFFFF. Reads occur at 0xFFFF, 0x0000, 0x0001.
- Ignored start: pulse `start` while `busy` and again during the `done` cycle. No extra `imRe` and no restart. A `start` one cycle after `done` begins a new dump.
- Reset mid-frame: assert `rst` during DATA bit 3. `tx`=1, `busy`=0, `imRe`=0 immediately without waiting for a clock edge. After release, the line stays high until a new `start`.
- Parity build: with `IMAGEN_UART_TX_PARITY_EN` defined, a byte of 0x07 yields parity bit 1, frame of 11 bits, 47-cycle pixel period, and `done` at 142 cycles.

Source files
------------

// File: rtl/imagen_uart_tx.sv
// imagen_uart_tx: streams image memory out on a UART TX line, one byte per pixel.
// Define IMAGEN_UART_TX_PARITY_EN for an even-parity bit (8E1); default is 8N1.
module imagen_uart_tx #(
  parameter int ADDR_W       = 16,
  parameter int N_PIXELS     = 65536,
  parameter int CLKS_PER_BIT = 434,
  parameter int RD_LAT       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] imRAddress,
  output logic              imRe,
  input  logic [7:0]        imRd,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 4);
  localparam logic [CNT_W-1:0] LP_BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] LP_RD_LAST = CNT_W'(RD_LAT);
  localparam logic [ADDR_W-1:0] LP_PIX_LAST = ADDR_W'(N_PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_bit;
  logic [7:0]         r_shift;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  r_pix;
  logic               w_bit_end;
  logic               w_rd_done;
  logic               w_imre;
  logic               w_tx;
  logic               w_busy;
  logic               w_done;
`ifdef IMAGEN_UART_TX_PARITY_EN
  logic               r_par;
`endif

  assign w_bit_end = (r_cnt == LP_BIT_LAST);
  assign w_rd_done = (r_cnt == LP_RD_LAST);

  assign imRAddress = r_addr;
  assign imRe       = w_imre;
  assign tx         = w_tx;
  assign busy       = w_busy;
  assign done       = w_done;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and output decode
  always_comb begin
    w_next = r_state;
    w_imre = 1'b0;
    w_tx   = 1'b1;
    w_busy = 1'b1;
    w_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        w_imre = (r_cnt == '0);
        if (w_rd_done) w_next = S_START;
      end
      S_START: begin
        w_tx = 1'b0;
        if (w_bit_end) w_next = S_DATA;
      end
      S_DATA: begin
        w_tx = r_shift[0];
        if (w_bit_end && r_bit == 3'd7) begin
`ifdef IMAGEN_UART_TX_PARITY_EN
          w_next = S_PARITY;
`else
          w_next = S_STOP;
`endif
        end
      end
`ifdef IMAGEN_UART_TX_PARITY_EN
      S_PARITY: begin
        w_tx = r_par;
        if (w_bit_end) w_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          if (r_pix == LP_PIX_LAST) w_next = S_DONE;
          else                      w_next = S_FETCH;
        end
      end
      S_DONE: begin
        w_busy = 1'b0;
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_busy = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  // Bit/fetch timer: restarts on each state change and each data bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_next != r_state ||
                 (r_state == S_DATA && w_bit_end)) begin
      r_cnt <= '0;
    end else if (r_state != S_IDLE) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Shift register: load the fetched pixel, shift out LSB first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_bit   <= '0;
    end else if (r_state == S_FETCH && w_rd_done) begin
      r_shift <= imRd;
      r_bit   <= '0;
    end else if (r_state == S_DATA && w_bit_end) begin
      r_shift <= {1'b0, r_shift[7:1]};
      r_bit   <= r_bit + 3'd1;
    end
  end

`ifdef IMAGEN_UART_TX_PARITY_EN
  // Even parity of the byte, captured with the byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               r_par <= 1'b0;
    else if (r_state == S_FETCH && w_rd_done) r_par <= ^imRd;
  end
`endif

  // Address and pixel count; address only advances when another read follows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
      r_pix  <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_addr <= base_addr;
      r_pix  <= '0;
    end else if (r_state == S_STOP && w_bit_end) begin
      r_pix <= r_pix + ADDR_W'(1);
      if (w_next == S_FETCH) r_addr <= r_addr + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_imagen_uart_tx.sv
// tb_imagen_uart_tx: directed checks of the image-dump UART transmitter.
// Models a 2-cycle-latency image memory and decodes the TX line per cycle.
module tb_imagen_uart_tx;

  localparam int AW  = 16;
  localparam int NP  = 3;
  localparam int CPB = 4;
  localparam int RL  = 2;
`ifdef IMAGEN_UART_TX_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif
  localparam int PER = RL + 1 + F * CPB;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] imRAddress;
  logic          imRe;
  logic [7:0]    imRd;
  logic          tx;
  logic          busy;
  logic          done;

  logic [7:0] mem [0:65535];
  logic [7:0] r_d1;

  int total;
  int bad;
  int cyc;

  imagen_uart_tx #(
    .ADDR_W(AW),
    .N_PIXELS(NP),
    .CLKS_PER_BIT(CPB),
    .RD_LAT(RL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .imRAddress(imRAddress),
    .imRe(imRe),
    .imRd(imRd),
    .tx(tx),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-stage read pipeline; poison value when no read was issued
  always_ff @(posedge clk) begin
    r_d1 <= imRe ? mem[imRAddress] : 8'h3C;
    imRd <= r_d1;
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_pixel(input string tag, input logic [AW-1:0] ad,
                          input logic [7:0] b, input int poke);
    logic [PER-1:0] re_v;
    logic [PER-1:0] tx_v;
    logic [PER-1:0] tx_e;
    logic [PER-1:0] bz_v;
    logic [PER-1:0] dn_v;
    logic [PER-1:0] ones;
    logic [10:0]    fr;
    logic [7:0]     dec;
`ifdef IMAGEN_UART_TX_PARITY_EN
    fr = {1'b1, ^b, b, 1'b0};
`else
    fr = {2'b11, b, 1'b0};
`endif
    ones = '1;
    for (int i = 0; i < PER; i++)
      tx_e[i] = (i < 3) ? 1'b1 : fr[(i - 3) / CPB];
    chk({tag, "_addr"}, 64'(imRAddress), 64'(ad));
    for (int i = 0; i < PER; i++) begin
      re_v[i] = imRe;
      tx_v[i] = tx;
      bz_v[i] = busy;
      dn_v[i] = done;
      start = (i == poke);
      step();
    end
    start = 1'b0;
    for (int j = 0; j < 8; j++)
      dec[j] = tx_v[3 + CPB * (j + 1) + 2];
    chk({tag, "_imre"}, 64'(re_v), 64'd1);
    chk({tag, "_txshape"}, 64'(tx_v), 64'(tx_e));
    chk({tag, "_byte"}, 64'(dec), 64'(b));
    chk({tag, "_busy"}, 64'(bz_v), 64'(ones));
    chk({tag, "_done0"}, 64'(dn_v), 64'd0);
  endtask

  task automatic dump(input string tag, input logic [AW-1:0] ba,
                      input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input int poke1);
    int k;
    start = 1'b1;
    base_addr = ba;
    step();
    start = 1'b0;
    k = cyc;
    do_pixel({tag, "_p0"}, ba, b0, -1);
    do_pixel({tag, "_p1"}, AW'(ba + 16'd1), b1, poke1);
    do_pixel({tag, "_p2"}, AW'(ba + 16'd2), b2, -1);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_done_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done_at"}, 64'(cyc - k + 1), 64'(NP * PER + 1));
  endtask

  initial begin
    logic [59:0] hi_v;
    logic [59:0] bz_v;
    total = 0;
    bad = 0;
    cyc = 0;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    mem[16'h0010] = 8'hA5;
    mem[16'h0011] = 8'h00;
    mem[16'h0012] = 8'hFF;
    mem[16'hFFFF] = 8'h5C;
    mem[16'h0000] = 8'h07;
    mem[16'h0001] = 8'h3E;

    step();
    step();
    chk("rst_tx", 64'(tx), 64'd1);
    chk("rst_imre", 64'(imRe), 64'd0);
    chk("rst_addr", 64'(imRAddress), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    step();
    chk("idle_tx", 64'(tx), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);

    dump("basic", 16'h0010, 8'hA5, 8'h00, 8'hFF, 10);

    start = 1'b1;
    base_addr = 16'h0010;
    step();
    chk("ign_busy", 64'(busy), 64'd0);
    chk("ign_imre", 64'(imRe), 64'd0);
    chk("ign_done", 64'(done), 64'd0);

    dump("restart", 16'h0010, 8'hA5, 8'h00, 8'hFF, -1);
    repeat (3) step();
    dump("wrap", 16'hFFFF, 8'h5C, 8'h07, 8'h3E, -1);
    step();
    step();

    start = 1'b1;
    base_addr = 16'h0010;
    step();
    start = 1'b0;
    repeat (20) step();
    chk("rm_pre_tx", 64'(tx), 64'd0);
    chk("rm_pre_busy", 64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rm_tx", 64'(tx), 64'd1);
    chk("rm_busy", 64'(busy), 64'd0);
    chk("rm_imre", 64'(imRe), 64'd0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      hi_v[i] = tx;
      bz_v[i] = busy | imRe;
    end
    chk("rm_line_high", 64'(hi_v), 64'hFFF_FFFF_FFFF_FFFF);
    chk("rm_quiet", 64'(bz_v), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
